// File: rtl/ff_layer_engine.sv
// ff_layer_engine: one dense layer y = act(W*x + b) in IEEE-754 single
// precision, N_LANES output neurons per group, one FP mul + add per lane.
// Ports: clk, rst (async active-low), start/n_in/n_out/relu_en and the four
// base addresses configure a layer; x_rd_* is the scalar read port, w_rd_*
// the wide read port (lane j in bits [32j+31:32j]), y_wr_* the result write
// port; busy/done/err report status. Optional macro FF_LEAKY_RELU_EN adds
// the leaky_en input (leaky ReLU, slope 1/8, priority over relu_en).
// FP units flush subnormals to zero and round to nearest even.

module ieee_754_multiplier #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        valid,
    output logic        busy
);
    logic [3:0] cnt;

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic              s;
        logic [7:0]        ex, ey;
        logic [23:0]       mx, my;
        logic [47:0]       p;
        logic signed [9:0] e;
        logic [22:0]       m;
        logic              g, st;
        logic [24:0]       r;
        s  = x[31] ^ y[31];
        ex = x[30:23];
        ey = y[30:23];
        mx = {1'b1, x[22:0]};
        my = {1'b1, y[22:0]};
        if ((ex == 8'hFF && x[22:0] != 23'd0) || (ey == 8'hFF && y[22:0] != 23'd0))
            return 32'h7FC00000;
        if (ex == 8'hFF || ey == 8'hFF)
            return (ex == 8'd0 || ey == 8'd0) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
        if (ex == 8'd0 || ey == 8'd0)
            return {s, 31'd0};
        p = mx * my;
        e = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'sd127;
        if (p[47]) begin
            m  = p[46:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = p[45:23];
            g  = p[22];
            st = |p[21:0];
        end
        r = {2'b01, m} + {24'd0, g & (st | m[0])};
        if (r[24]) e = e + 10'sd1;
        if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 10'sd0) return {s, 31'd0};
        return {s, e[7:0], r[22:0]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            result <= '0;
        end else if (start) begin
            result <= fmul(a, b);
            cnt    <= 4'(LAT);
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign valid = (cnt == 4'd1);
    assign busy  = (cnt != 4'd0);
endmodule

module ieee_754_adder #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        valid,
    output logic        busy
);
    logic [3:0] cnt;

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [7:0]        ex, ey, el, es;
        logic              sl, ss, up;
        logic [23:0]       ml, ms;
        logic [7:0]        d;
        logic [50:0]       t;
        logic [26:0]       al, as;
        logic [27:0]       sum;
        logic [26:0]       n;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic [24:0]       r;
        ex = x[30:23];
        ey = y[30:23];
        if ((ex == 8'hFF && x[22:0] != 23'd0) || (ey == 8'hFF && y[22:0] != 23'd0))
            return 32'h7FC00000;
        if (ex == 8'hFF)
            return (ey == 8'hFF && x[31] != y[31]) ? 32'h7FC00000 : x;
        if (ey == 8'hFF) return y;
        if (ex == 8'd0 && ey == 8'd0) return {x[31] & y[31], 31'd0};
        if (ex == 8'd0) return y;
        if (ey == 8'd0) return x;
        // Order operands by magnitude so the difference is never negative.
        if (x[30:0] >= y[30:0]) begin
            sl = x[31]; el = ex; ml = {1'b1, x[22:0]};
            ss = y[31]; es = ey; ms = {1'b1, y[22:0]};
        end else begin
            sl = y[31]; el = ey; ml = {1'b1, y[22:0]};
            ss = x[31]; es = ex; ms = {1'b1, x[22:0]};
        end
        d  = el - es;
        al = {ml, 3'b000};
        // Alignment keeps guard/round bits plus a sticky bit in bit 0.
        if (d > 8'd26) begin
            t  = '0;
            as = 27'd1;
        end else begin
            t  = {ms, 27'd0} >> d;
            as = {t[50:25], |t[24:0]};
        end
        if (sl == ss) sum = {1'b0, al} + {1'b0, as};
        else          sum = {1'b0, al} - {1'b0, as};
        if (sum == 28'd0) return 32'd0;
        e = $signed({2'b00, el});
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
        end else begin
            lz = '0;
            for (int i = 0; i < 27; i++)
                if (sum[i]) lz = 5'(26 - i);
            n = sum[26:0] << lz;
            e = e - $signed({5'd0, lz});
        end
        up = n[2] & (n[1] | n[0] | n[3]);
        r  = {1'b0, n[26:3]} + {24'd0, up};
        if (r[24]) e = e + 10'sd1;
        if (e >= 10'sd255) return {sl, 8'hFF, 23'd0};
        if (e <= 10'sd0) return {sl, 31'd0};
        return {sl, e[7:0], r[22:0]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            result <= '0;
        end else if (strt) begin
            result <= fadd(a, b);
            cnt    <= 4'(LAT);
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign valid = (cnt == 4'd1);
    assign busy  = (cnt != 4'd0);
endmodule

module ff_layer_engine #(
    parameter int N_LANES = 4,
    parameter int ADDR_W  = 9,
    parameter int IDX_W   = 8,
    parameter int MAX_IN  = 64,
    parameter int MAX_OUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_W-1:0]     n_in,
    input  logic [IDX_W-1:0]     n_out,
    input  logic                 relu_en,
`ifdef FF_LEAKY_RELU_EN
    input  logic                 leaky_en,
`endif
    input  logic [ADDR_W-1:0]    x_base,
    input  logic [ADDR_W-1:0]    w_base,
    input  logic [ADDR_W-1:0]    b_base,
    input  logic [ADDR_W-1:0]    y_base,
    output logic                 x_rd_en,
    output logic [ADDR_W-1:0]    x_rd_addr,
    input  logic [31:0]          x_rd_data,
    output logic                 w_rd_en,
    output logic [ADDR_W-1:0]    w_rd_addr,
    input  logic [32*N_LANES-1:0] w_rd_data,
    output logic                 y_wr_en,
    output logic [ADDR_W-1:0]    y_wr_addr,
    output logic [31:0]          y_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] GRP_INIT = 4'd1;
    localparam logic [3:0] RD       = 4'd2;
    localparam logic [3:0] RD_WAIT  = 4'd3;
    localparam logic [3:0] MUL      = 4'd4;
    localparam logic [3:0] ADD      = 4'd5;
    localparam logic [3:0] B_RD     = 4'd6;
    localparam logic [3:0] B_WAIT   = 4'd7;
    localparam logic [3:0] B_ADD    = 4'd8;
    localparam logic [3:0] WRITE    = 4'd9;
    localparam logic [3:0] DONE     = 4'd10;

    logic [3:0]         state;
    logic [IDX_W-1:0]   n_in_q, k, g, rem;
    logic               relu_q;
`ifdef FF_LEAKY_RELU_EN
    logic               leaky_q;
`endif
    logic [ADDR_W-1:0]  x_base_q, b_base_q, w_ptr, y_ptr;
    logic [LW-1:0]      lane;
    logic               issued, err_q;
    logic [N_LANES-1:0] got;
    logic [31:0]        xq;
    logic [31:0]        wq[N_LANES];
    logic [31:0]        acc[N_LANES];
    logic [31:0]        prod[N_LANES];
    logic [31:0]        sum_q[N_LANES];
    logic [31:0]        bias[N_LANES];
    logic [31:0]        add_b[N_LANES];
    logic [31:0]        mul_res[N_LANES];
    logic [31:0]        add_res[N_LANES];
    logic [N_LANES-1:0] mul_valid, mul_busy, add_valid, add_busy;
    logic               mul_go, add_go, mul_all, add_all, bad_cfg, last_lane;
    logic [IDX_W-1:0]   lane_cnt;
    logic [31:0]        acc_sel, act_val;

    // Units are only started once every lane has gone idle.
    assign mul_go  = (state == MUL) && !issued && !(|mul_busy);
    assign add_go  = ((state == ADD) || (state == B_ADD)) && !issued && !(|add_busy);
    assign mul_all = &(got | mul_valid);
    assign add_all = &(got | add_valid);

    assign bad_cfg = (n_in == '0) || (n_out == '0) ||
                     (int'(n_in) > MAX_IN) || (int'(n_out) > MAX_OUT);

    // rem is the neuron count left from the current group onward.
    assign lane_cnt  = (rem > IDX_W'(N_LANES)) ? IDX_W'(N_LANES) : rem;
    assign last_lane = (IDX_W'(lane) == lane_cnt - IDX_W'(1));

    for (genvar j = 0; j < N_LANES; j++) begin : g_lane
        assign add_b[j] = (state == B_ADD) ? bias[j] : prod[j];

        ieee_754_multiplier #(.LAT(1 + (j % 3))) u_mul (
            .clk    (clk),
            .rst    (rst),
            .start  (mul_go),
            .a      (xq),
            .b      (wq[j]),
            .result (mul_res[j]),
            .valid  (mul_valid[j]),
            .busy   (mul_busy[j])
        );

        ieee_754_adder #(.LAT(1 + ((j + 1) % 2))) u_add (
            .clk    (clk),
            .rst    (rst),
            .strt   (add_go),
            .a      (acc[j]),
            .b      (add_b[j]),
            .result (add_res[j]),
            .valid  (add_valid[j]),
            .busy   (add_busy[j])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            n_in_q   <= '0;
            k        <= '0;
            g        <= '0;
            rem      <= '0;
            relu_q   <= 1'b0;
`ifdef FF_LEAKY_RELU_EN
            leaky_q  <= 1'b0;
`endif
            x_base_q <= '0;
            b_base_q <= '0;
            w_ptr    <= '0;
            y_ptr    <= '0;
            lane     <= '0;
            issued   <= 1'b0;
            got      <= '0;
            err_q    <= 1'b0;
            xq       <= '0;
            for (int j = 0; j < N_LANES; j++) begin
                wq[j]    <= '0;
                acc[j]   <= '0;
                prod[j]  <= '0;
                sum_q[j] <= '0;
                bias[j]  <= '0;
            end
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_cfg) begin
                            err_q <= 1'b1;
                        end else begin
                            n_in_q   <= n_in;
                            rem      <= n_out;
                            relu_q   <= relu_en;
`ifdef FF_LEAKY_RELU_EN
                            leaky_q  <= leaky_en;
`endif
                            x_base_q <= x_base;
                            b_base_q <= b_base;
                            w_ptr    <= w_base;
                            y_ptr    <= y_base;
                            g        <= '0;
                            state    <= GRP_INIT;
                        end
                    end
                end
                GRP_INIT: begin
                    for (int j = 0; j < N_LANES; j++) acc[j] <= '0;
                    k      <= '0;
                    issued <= 1'b0;
                    got    <= '0;
                    state  <= RD;
                end
                RD: begin
                    // Weight rows of consecutive groups are contiguous.
                    w_ptr <= w_ptr + ADDR_W'(1);
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    xq <= x_rd_data;
                    for (int j = 0; j < N_LANES; j++)
                        wq[j] <= w_rd_data[32*j +: 32];
                    state <= MUL;
                end
                MUL: begin
                    if (mul_go) begin
                        issued <= 1'b1;
                    end else if (issued) begin
                        for (int j = 0; j < N_LANES; j++)
                            if (mul_valid[j]) prod[j] <= mul_res[j];
                        got <= got | mul_valid;
                        if (mul_all) begin
                            issued <= 1'b0;
                            got    <= '0;
                            state  <= ADD;
                        end
                    end
                end
                ADD, B_ADD: begin
                    if (add_go) begin
                        issued <= 1'b1;
                    end else if (issued) begin
                        for (int j = 0; j < N_LANES; j++)
                            if (add_valid[j]) sum_q[j] <= add_res[j];
                        got <= got | add_valid;
                        if (add_all) begin
                            for (int j = 0; j < N_LANES; j++)
                                acc[j] <= add_valid[j] ? add_res[j] : sum_q[j];
                            issued <= 1'b0;
                            got    <= '0;
                            if (state == B_ADD) begin
                                lane  <= '0;
                                state <= WRITE;
                            end else if (k == n_in_q - IDX_W'(1)) begin
                                state <= B_RD;
                            end else begin
                                k     <= k + IDX_W'(1);
                                state <= RD;
                            end
                        end
                    end
                end
                B_RD: state <= B_WAIT;
                B_WAIT: begin
                    for (int j = 0; j < N_LANES; j++)
                        bias[j] <= w_rd_data[32*j +: 32];
                    state <= B_ADD;
                end
                WRITE: begin
                    y_ptr <= y_ptr + ADDR_W'(1);
                    if (last_lane) begin
                        if (rem > IDX_W'(N_LANES)) begin
                            rem   <= rem - IDX_W'(N_LANES);
                            g     <= g + IDX_W'(1);
                            state <= GRP_INIT;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        lane <= lane + LW'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign acc_sel = acc[lane];

    always_comb begin
        act_val = acc_sel;
        if (relu_q && acc_sel[31]) act_val = 32'h00000000;
`ifdef FF_LEAKY_RELU_EN
        // Divide by 8 via the exponent; tiny values collapse to signed zero.
        if (leaky_q && acc_sel[31]) begin
            if (acc_sel[30:23] == 8'hFF)
                act_val = acc_sel;
            else if (acc_sel[30:23] <= 8'd3)
                act_val = 32'h80000000;
            else
                act_val = {1'b1, acc_sel[30:23] - 8'd3, acc_sel[22:0]};
        end
`endif
    end

    assign x_rd_en   = (state == RD);
    assign x_rd_addr = x_rd_en ? x_base_q + ADDR_W'(k) : '0;
    assign w_rd_en   = (state == RD) || (state == B_RD);
    assign w_rd_addr = (state == RD)   ? w_ptr :
                       (state == B_RD) ? b_base_q + ADDR_W'(g) : '0;
    assign y_wr_en   = (state == WRITE);
    assign y_wr_addr = y_wr_en ? y_ptr : '0;
    assign y_wr_data = y_wr_en ? act_val : '0;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign err       = err_q;
endmodule
